// File: rtl/register_bank.sv
// Multi-word register storage: one load/increment write port and two
// combinational read ports, with optional write-to-read forwarding.
module register_bank #(
   parameter int WIDTH  = 16,
   parameter int DEPTH  = 8,
   parameter int ADDR_W = 3,
   parameter bit BYPASS = 1'b1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              load,
   input  logic              inc,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [WIDTH-1:0]  in,
   input  logic [ADDR_W-1:0] rd_addr_a,
   output logic [WIDTH-1:0]  out_a,
   input  logic [ADDR_W-1:0] rd_addr_b,
   output logic [WIDTH-1:0]  out_b,
   output logic              busy_wr
);

   // One extra bit so DEPTH == 2**ADDR_W still compares correctly.
   localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

   logic [WIDTH-1:0] regs [DEPTH];
   logic             wr_valid;
   logic             wr_en;
   logic [WIDTH-1:0] wr_cur;
   logic [WIDTH-1:0] wr_next;

   assign wr_valid = ({1'b0, wr_addr} < DEPTH_L);
   assign wr_en    = (load | inc) & wr_valid & ~reset;

   always_comb begin
      wr_cur = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (wr_addr == ADDR_W'(i)) wr_cur = regs[i];
      end
   end

   // Load has priority over increment; increment wraps modulo 2**WIDTH.
   assign wr_next = load ? in : wr_cur + WIDTH'(1);

   always_comb begin
      out_a = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (rd_addr_a == ADDR_W'(i)) out_a = regs[i];
      end
      if (BYPASS && wr_en && (rd_addr_a == wr_addr)) out_a = wr_next;
   end

   always_comb begin
      out_b = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (rd_addr_b == ADDR_W'(i)) out_b = regs[i];
      end
      if (BYPASS && wr_en && (rd_addr_b == wr_addr)) out_b = wr_next;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
         busy_wr <= 1'b0;
      end else begin
         busy_wr <= wr_en;
         for (int i = 0; i < DEPTH; i++) begin
            if (wr_en && (wr_addr == ADDR_W'(i))) regs[i] <= wr_next;
         end
      end
   end

endmodule

// File: doc/register_bank.md
Name: register_bank

Overview:
- Parametrised multi-register storage block. It is the successor to the fixed 16-bit single register.
- Holds DEPTH words of WIDTH bits and provides one write/increment port and two independent read ports.
- Intended for the CPU datapath: general registers, A/D-style scratch registers, and small counter banks.
- Adds synchronous clear, in-place increment, out-of-range protection and optional write-to-read bypass.

Parameters:
WIDTH, 16, data word width in bits (>=1)
DEPTH, 8, number of registers (>=2; need not be a power of two)
ADDR_W, 3, address width; must satisfy 2**ADDR_W >= DEPTH
BYPASS, 1, 1 = a read of the register being written returns the next value in the same cycle; 0 = the read returns the stored value

Ports:
clk  input  1  clock; all state updates on its rising edge
reset  input  1  synchronous, active-high; clears all registers
load  input  1  write enable: at the edge, reg[wr_addr] <= in
inc  input  1  increment enable: at the edge, reg[wr_addr] <= reg[wr_addr] + 1
wr_addr  input  ADDR_W  target register for load/inc
in  input  WIDTH  write data
rd_addr_a  input  ADDR_W  read port A address
out_a  output  WIDTH  read port A data (combinational)
rd_addr_b  input  ADDR_W  read port B address
out_b  output  WIDTH  read port B data (combinational)
busy_wr  output  1  registered flag: 1 for the cycle after an accepted load/inc, 0 otherwise

Behaviour:
- Reset values:
  - Every reg[i] = 0.
  - busy_wr = 0.
  - Both outputs read 0 from the cycle after reset is sampled high.
- Priority at each rising edge, highest first:
  1. reset: all registers cleared; load and inc ignored.
  2. load: reg[wr_addr] <= in.
  3. inc: reg[wr_addr] <= reg[wr_addr] + 1.
  4. None active: all registers hold.
- Simultaneous load and inc: load wins; the increment is discarded.
- Increment arithmetic: modulo 2**WIDTH. All-ones wraps to 0. No carry output.
- Register isolation: only the addressed register changes. All other registers hold.
- Out-of-range write (wr_addr >= DEPTH):
  - load/inc is ignored; no register changes.
  - busy_wr stays 0 next cycle.
- Out-of-range read (rd_addr >= DEPTH): the port outputs 0.
- Read latency: 0 cycles (combinational from address and stored state). The two ports are fully independent and may use the same address.
- Bypass behaviour, for each port whose read address equals a valid wr_addr while load|inc is active and reset is low:
  - BYPASS=1: the port shows the value that will be stored at the next edge (in for load, reg+1 for inc).
  - BYPASS=0: the port shows the current stored value.
- Reset and bypass: while reset is high, bypass is suppressed and outputs show stored contents. The new value (0) appears after the edge.
- busy_wr: set to 1 for one cycle after any accepted (in-range, non-reset) load or inc edge.
- Reset mid-operation: a reset edge overrides a pending load/inc. Register contents become 0 and busy_wr becomes 0.
- Timing: no multi-cycle operations; every write completes at the sampling edge.

Test Plan:
- Reset clears: fill reg0..reg7 with 16'h1111..16'h8888, pulse reset 1 cycle -> all reads = 16'h0000, busy_wr = 0.
- Load/isolation: load 16'hBEEF to addr 3 -> out_a(addr 3) = 16'hBEEF after edge; out_b(addr 2) still 16'h0000; busy_wr = 1 for exactly one cycle.
- Increment wrap: load 16'hFFFE to addr 5, inc twice -> reads 16'hFFFF, then 16'h0000; stepping through all 2**16 values (0 -> FFFF -> 0) matches a model counter.
- Priority: load=1, inc=1, in=16'h0042 on addr 1 -> reg1 = 16'h0042. reset=1 with load=1 on addr 1 -> reg1 = 16'h0000.
- Bypass: with BYPASS=1, load 16'h1234 to addr 4 while rd_addr_a=4 -> out_a = 16'h1234 before the edge. With BYPASS=0, same stimulus -> out_a keeps the old value until after the edge. Check both ports at the same address.
- Out-of-range: DEPTH=6, ADDR_W=3; load 16'hAAAA at addr 6 -> no register changes, busy_wr = 0; read addr 7 -> 16'h0000. Rerun with WIDTH=8 to confirm wrap from 8'hFF to 8'h00.
